// File: rtl/note_sequencer.sv
// note_sequencer
//   Steps through a table of note periods at a programmable tempo and presents
//   the current period on songout. The sequencer can walk the table up, down,
//   ping-pong, or hold a single note. It can loop forever or play once.
//
// Ports
//   clk50      in   1                   system clock, all logic on rising edge
//   reset      in   1                   asynchronous active-low reset
//   notes_flat in   NUM_NOTES*NOTE_W    note i at [i*NOTE_W +: NOTE_W]; 0 = rest
//   tempo_div  in   DIV_W               step length is tempo_div+1 cycles
//   mode       in   2                   00 up, 01 down, 10 ping-pong, 11 hold
//   loop       in   1                   1 wraps at sequence end, 0 one-shot
//   start      in   1                   single-cycle start / restart request
//   stop       in   1                   single-cycle stop request
//   songout    out  NOTE_W              current note period, 0 when idle
//   note_idx   out  IDX_W               current table index
//   step       out  1                   pulse on every new note (incl. restrikes)
//   busy       out  1                   high while playing
//   done       out  1                   pulse when a one-shot sequence completes
module note_sequencer #(
    parameter int NOTE_W    = 16,
    parameter int NUM_NOTES = 36,
    parameter int DIV_W     = 24,
    parameter int IDX_W     = 6
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic [NUM_NOTES*NOTE_W-1:0]   notes_flat,
    input  logic [DIV_W-1:0]              tempo_div,
    input  logic [1:0]                    mode,
    input  logic                          loop,
    input  logic                          start,
    input  logic                          stop,
    output logic [NOTE_W-1:0]             songout,
    output logic [IDX_W-1:0]              note_idx,
    output logic                          step,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic { S_IDLE, S_PLAY } state_t;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

    state_t            state;
    logic [DIV_W-1:0]  count;
    logic              dir_down;

    logic              tick;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  adv_idx;
    logic              adv_dir_down;
    logic              adv_finish;
    logic [NOTE_W-1:0] start_note;
    logic [NOTE_W-1:0] adv_note;
    logic [NOTE_W-1:0] cur_note;

    // Table lookup by index; indices past the table read as a rest.
    function automatic logic [NOTE_W-1:0] note_at(input logic [IDX_W-1:0] i);
        logic [NOTE_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (i == IDX_W'(k)) v = notes_flat[k*NOTE_W +: NOTE_W];
        end
        return v;
    endfunction

    // A lowered tempo_div can leave count above it; >= then ticks at once
    // instead of waiting for the counter to wrap.
    assign tick      = (count >= tempo_div);
    assign start_idx = (mode_t'(mode) == MODE_DOWN) ? LAST_IDX : '0;

    // Next index / direction for a tick, using the live mode and loop.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves one
        // unassigned, which would infer a latch.
        adv_idx      = note_idx;
        adv_dir_down = dir_down;
        adv_finish   = 1'b0;
        case (mode_t'(mode))
            MODE_UP: begin
                adv_dir_down = 1'b0;
                if (note_idx == LAST_IDX) begin
                    if (loop) adv_idx    = '0;
                    else      adv_finish = 1'b1;
                end else begin
                    adv_idx = note_idx + IDX_W'(1);
                end
            end
            MODE_DOWN: begin
                adv_dir_down = 1'b1;
                if (note_idx == '0) begin
                    if (loop) adv_idx    = LAST_IDX;
                    else      adv_finish = 1'b1;
                end else begin
                    adv_idx = note_idx - IDX_W'(1);
                end
            end
            MODE_PING: begin
                // Endpoints are played once per pass: turn around on the
                // tick that leaves them, not by repeating them.
                if (!dir_down) begin
                    if (note_idx == LAST_IDX) begin
                        adv_idx      = LAST_IDX - IDX_W'(1);
                        adv_dir_down = 1'b1;
                    end else begin
                        adv_idx = note_idx + IDX_W'(1);
                    end
                end else if (note_idx == '0) begin
                    if (loop) begin
                        adv_idx      = IDX_W'(1);
                        adv_dir_down = 1'b0;
                    end else begin
                        adv_finish = 1'b1;
                    end
                end else begin
                    adv_idx = note_idx - IDX_W'(1);
                end
            end
            MODE_HOLD: begin
                adv_idx = note_idx;
            end
            default: begin
                adv_idx = note_idx;
            end
        endcase
    end

    always_comb begin
        start_note = note_at(start_idx);
        adv_note   = note_at(adv_idx);
        cur_note   = note_at(note_idx);
    end

    // Priority: stop (only meaningful in PLAY) > start > tick.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            state    <= S_IDLE;
            count    <= '0;
            note_idx <= '0;
            dir_down <= 1'b0;
            songout  <= '0;
            step     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (state == S_PLAY && stop) begin
            state   <= S_IDLE;
            count   <= '0;
            songout <= '0;
            step    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            state    <= S_PLAY;
            count    <= '0;
            note_idx <= start_idx;
            dir_down <= (mode_t'(mode) == MODE_DOWN);
            songout  <= start_note;
            step     <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (state == S_PLAY) begin
            if (tick) begin
                count <= '0;
                if (adv_finish) begin
                    // note_idx keeps the last index played.
                    state   <= S_IDLE;
                    songout <= '0;
                    step    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    note_idx <= adv_idx;
                    dir_down <= adv_dir_down;
                    songout  <= adv_note;
                    step     <= 1'b1;
                    done     <= 1'b0;
                end
            end else begin
                count   <= count + DIV_W'(1);
                // Re-read the table so edits to notes_flat show up mid-note.
                songout <= cur_note;
                step    <= 1'b0;
                done    <= 1'b0;
            end
        end else begin
            step <= 1'b0;
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
//   Directed scenarios for the documented behaviours, followed by a randomized
//   run compared every cycle against a reference model. The model derives the
//   index from the number of ticks since start using closed-form sequences,
//   instead of stepping an index/direction pair.
module tb_note_sequencer;

    localparam int NW = 16;
    localparam int NN = 4;
    localparam int DW = 8;
    localparam int IW = 3;

    logic              clk50 = 1'b0;
    logic              reset;
    logic [NN*NW-1:0]  notes_flat;
    logic [DW-1:0]     tempo_div;
    logic [1:0]        mode;
    logic              loop;
    logic              start;
    logic              stop;
    logic [NW-1:0]     songout;
    logic [IW-1:0]     note_idx;
    logic              step;
    logic              busy;
    logic              done;

    logic [NW-1:0]     notes [NN];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit m_busy;
    int m_k;      // ticks since the last start
    int m_cnt;    // cycles since the last step
    int m_idx;
    int m_song;
    bit m_step;
    bit m_done;

    note_sequencer #(
        .NOTE_W(NW), .NUM_NOTES(NN), .DIV_W(DW), .IDX_W(IW)
    ) dut (
        .clk50(clk50), .reset(reset), .notes_flat(notes_flat),
        .tempo_div(tempo_div), .mode(mode), .loop(loop),
        .start(start), .stop(stop), .songout(songout),
        .note_idx(note_idx), .step(step), .busy(busy), .done(done)
    );

    always #5 clk50 = ~clk50;

    always_comb begin
        notes_flat = '0;
        for (int i = 0; i < NN; i++) notes_flat[i*NW +: NW] = notes[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Index played on the k-th tick after start for a fixed mode.
    function automatic int ref_idx(input int md, input int k);
        int p;
        case (md)
            0: return k % NN;
            1: return NN - 1 - (k % NN);
            2: begin
                p = k % (2*NN - 2);
                return (p < NN) ? p : (2*NN - 2 - p);
            end
            default: return 0;
        endcase
    endfunction

    // One-shot length: up/down play NN notes, ping-pong plays 2*NN-1.
    function automatic bit ref_finished(input int md, input bit lp, input int k);
        if (lp) return 1'b0;
        case (md)
            0, 1:    return k >= NN;
            2:       return k >= 2*NN - 1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_cnt = 0; m_idx = 0;
        m_song = 0; m_step = 0; m_done = 0;
    endtask

    // Expected state after the coming edge, from the inputs now applied.
    task automatic model_step();
        if (m_busy && stop) begin
            m_busy = 0; m_song = 0; m_step = 0; m_done = 0;
        end else if (start) begin
            m_busy = 1; m_k = 0; m_cnt = 0;
            m_idx  = ref_idx(int'(mode), 0);
            m_song = int'(notes[m_idx]);
            m_step = 1; m_done = 0;
        end else if (m_busy) begin
            if (m_cnt >= int'(tempo_div)) begin
                m_k++;
                m_cnt = 0;
                if (ref_finished(int'(mode), loop, m_k)) begin
                    m_busy = 0; m_song = 0; m_step = 0; m_done = 1;
                end else begin
                    m_idx  = ref_idx(int'(mode), m_k);
                    m_song = int'(notes[m_idx]);
                    m_step = 1; m_done = 0;
                end
            end else begin
                m_cnt++;
                m_song = int'(notes[m_idx]);
                m_step = 0; m_done = 0;
            end
        end else begin
            m_step = 0; m_done = 0;
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ":songout"},  32'(songout),  32'(m_song));
        check({ph, ":note_idx"}, 32'(note_idx), 32'(m_idx));
        check({ph, ":step"},     32'(step),     32'(m_step));
        check({ph, ":busy"},     32'(busy),     32'(m_busy));
        check({ph, ":done"},     32'(done),     32'(m_done));
    endtask

    // Apply current inputs for one edge, then compare just after it.
    task automatic cycle(input string ph);
        model_step();
        @(posedge clk50);
        #1;
        compare_all(ph);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int exp_up[5];
        int seq_pp[8];
        int exp_dn[4];

        exp_up = '{10, 20, 30, 40, 10};
        seq_pp = '{0, 1, 2, 3, 2, 1, 0, 1};
        exp_dn = '{40, 30, 20, 10};

        reset = 1'b0; start = 1'b0; stop = 1'b0;
        mode = 2'b00; loop = 1'b1; tempo_div = 8'd2;
        notes[0] = 16'd10; notes[1] = 16'd20; notes[2] = 16'd30; notes[3] = 16'd40;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk50);
        #1;
        compare_all("reset");
        reset = 1'b1;
        cycle("idle_after_reset");

        // Up, looping: each note for 3 cycles, step every 3 cycles.
        mode = 2'b00; loop = 1'b1; start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            cycle("up");
            check("up_song", 32'(songout), 32'(exp_up[c/3]));
            check("up_step", 32'(step), 32'((c % 3) == 0));
            check("up_busy", 32'(busy), 32'd1);
        end
        stop = 1'b1;
        cycle("up_stop");

        // Ping-pong, looping.
        mode = 2'b10; loop = 1'b1; start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            cycle("ping");
            check("ping_idx",  32'(note_idx), 32'(seq_pp[c/3]));
            check("ping_song", 32'(songout),  32'((seq_pp[c/3] + 1) * 10));
        end
        stop = 1'b1;
        cycle("ping_stop");

        // Down, one-shot, ending with a done pulse.
        mode = 2'b01; loop = 1'b0; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cycle("down");
            check("down_song", 32'(songout), 32'(exp_dn[c/3]));
        end
        cycle("down_end");
        check("down_done",  32'(done),     32'd1);
        check("down_song0", 32'(songout),  32'd0);
        check("down_busy0", 32'(busy),     32'd0);
        check("down_idx0",  32'(note_idx), 32'd0);
        cycle("down_after");
        check("down_done_pulse", 32'(done), 32'd0);

        // Stop, start and tick in the same cycle: stop wins.
        mode = 2'b00; loop = 1'b1; start = 1'b1;
        cycle("prio_start");
        cycle("prio_run");
        cycle("prio_run");
        stop = 1'b1; start = 1'b1;
        cycle("prio");
        check("prio_busy", 32'(busy),    32'd0);
        check("prio_song", 32'(songout), 32'd0);
        check("prio_step", 32'(step),    32'd0);
        check("prio_done", 32'(done),    32'd0);

        // Live tempo change with the counter at 5.
        tempo_div = 8'd10; start = 1'b1;
        cycle("tempo_start");
        for (int c = 0; c < 5; c++) cycle("tempo_wait");
        tempo_div = 8'd1;
        for (int c = 0; c < 5; c++) begin
            cycle("tempo");
            check("tempo_step", 32'(step), 32'((c % 2) == 0));
        end
        stop = 1'b1;
        cycle("tempo_stop");

        // Hold with tempo_div=0: restrike every cycle on the same index.
        mode = 2'b11; tempo_div = 8'd0; start = 1'b1;
        cycle("hold_start");
        for (int c = 0; c < 4; c++) begin
            cycle("hold");
            check("hold_step", 32'(step),     32'd1);
            check("hold_idx",  32'(note_idx), 32'd0);
        end

        // Reset between edges mid-play.
        mode = 2'b00; tempo_div = 8'd2; start = 1'b1;
        cycle("rst_play");
        cycle("rst_play");
        cycle("rst_play");
        cycle("rst_play");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_song", 32'(songout),  32'd0);
        check("rst_idx",  32'(note_idx), 32'd0);
        check("rst_step", 32'(step),     32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        repeat (2) @(posedge clk50);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle("post_rst");
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        // Randomized run; mode and loop only change alongside a start.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 24) == 0) begin
                start = 1'b1;
                mode  = 2'($urandom_range(0, 3));
                loop  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 59) == 0) stop = 1'b1;
            if ($urandom_range(0, 29) == 0) tempo_div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) notes[$urandom_range(0, NN-1)] = 16'($urandom_range(0, 100));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
